// File: rtl/bitwise_batch_accumulator_if.sv
// rtl/bitwise_batch_accumulator_if.sv - command, operand and result bundle for the batch accumulator
interface bitwise_batch_accumulator_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output start, op, len, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  start, op, len, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/bitwise_batch_accumulator.sv
// rtl/bitwise_batch_accumulator.sv - folds a batch of operands with a 4-bit bitwise operator
module bitwise_batch_accumulator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    bitwise_batch_accumulator_if.slave    bus
);
    // S_FLUSH is the single idle beat of an empty batch so its result appears two cycles after start
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] op_result;
    logic             beat;

    assign beat = (state_q == S_RUN) && bus.in_valid;

    // Apply the latched operator to the accumulator and the incoming operand
    always_comb begin
        op_result = '0;
        case (op_q)
            3'd0:    op_result = acc_q & bus.in_data;
            3'd1:    op_result = acc_q | bus.in_data;
            3'd2:    op_result = acc_q ^ bus.in_data;
            3'd3:    op_result = ~acc_q;
            3'd4:    op_result = ~(acc_q & bus.in_data);
            3'd5:    op_result = ~(acc_q | bus.in_data);
            3'd6:    op_result = ~(acc_q ^ bus.in_data);
            default: op_result = bus.in_data;
        endcase
    end

    // Batch sequencing: latch command, accept beats, hold result until consumed
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    len_d   = bus.len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (bus.len != CNT_ZERO) ? S_RUN : S_FLUSH;
                end
            end
            S_RUN: begin
                if (beat) begin
                    // first beat seeds the accumulator regardless of operator
                    acc_d = (cnt_q == CNT_ZERO) ? bus.in_data : op_result;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            op_q    <= op_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = acc_q;
    assign bus.out_count = cnt_q;
endmodule
